// File: rtl/reg_file_wb_arbiter_if.sv
// Bus bundle for reg_file_wb_arbiter: primary/secondary write requests, register-file
// write port and scoreboard queries. Handshakes transfer on valid && ready; requesters hold addr/data while stalled.
interface reg_file_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  i_p_valid;
    logic [ADDR_WIDTH-1:0] i_p_addr;
    logic [DATA_WIDTH-1:0] i_p_data;
    logic                  o_p_ready;
    logic                  i_s_valid;
    logic [ADDR_WIDTH-1:0] i_s_addr;
    logic [DATA_WIDTH-1:0] i_s_data;
    logic                  o_s_ready;
    logic                  o_rd_wren;
    logic [ADDR_WIDTH-1:0] o_rd_addr;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic [ADDR_WIDTH-1:0] i_chk_addr1;
    logic [ADDR_WIDTH-1:0] i_chk_addr2;
    logic                  o_chk_busy1;
    logic                  o_chk_busy2;

    modport slave (
        input  i_p_valid, i_p_addr, i_p_data,
        output o_p_ready,
        input  i_s_valid, i_s_addr, i_s_data,
        output o_s_ready,
        output o_rd_wren, o_rd_addr, o_rd_data,
        input  i_chk_addr1, i_chk_addr2,
        output o_chk_busy1, o_chk_busy2
    );

    modport master (
        output i_p_valid, i_p_addr, i_p_data,
        input  o_p_ready,
        output i_s_valid, i_s_addr, i_s_data,
        input  o_s_ready,
        input  o_rd_wren, o_rd_addr, o_rd_data,
        output i_chk_addr1, i_chk_addr2,
        input  o_chk_busy1, o_chk_busy2
    );
endinterface

// File: rtl/reg_file_wb_arbiter.sv
// Register-file write-port arbiter: primary writeback vs FIFO-buffered secondary with starvation limit.
// Optional macro WB_ARB_BYPASS_EN: grant an idle-cycle secondary request directly when the FIFO is empty.
module reg_file_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    reg_file_wb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_vld;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [STV_W-1:0]      r_starve;
    logic                  r_rd_wren;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_out_sec;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_force;
    logic                  w_pop;
    logic                  w_byp;
    logic                  w_push;
    logic                  w_g_valid;
    logic                  w_g_sec;
    logic [ADDR_WIDTH-1:0] w_g_addr;
    logic [DATA_WIDTH-1:0] w_g_data;
    logic [FIFO_DEPTH-1:0] w_vld_nxt;
    logic                  w_busy1;
    logic                  w_busy2;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_force = !w_empty && (r_starve == STV_W'(STARVE_MAX));
    assign w_pop   = !w_empty && (w_force || !bus.i_p_valid);

`ifdef WB_ARB_BYPASS_EN
    // Empty FIFO implies no force, so an idle primary leaves the port free for a direct grant.
    assign w_byp = w_empty && !bus.i_p_valid && bus.i_s_valid;
`else
    assign w_byp = 1'b0;
`endif

    assign w_push = bus.i_s_valid && !w_full && !w_byp;

    assign bus.o_p_ready = !w_force;
    assign bus.o_s_ready = !w_full;

    always_comb begin
        w_g_valid = 1'b0;
        w_g_sec   = 1'b0;
        w_g_addr  = '0;
        w_g_data  = '0;
        if (w_pop) begin
            w_g_valid = 1'b1;
            w_g_sec   = 1'b1;
            w_g_addr  = r_fifo_addr[r_rd_ptr];
            w_g_data  = r_fifo_data[r_rd_ptr];
        end else if (bus.i_p_valid) begin
            w_g_valid = 1'b1;
            w_g_addr  = bus.i_p_addr;
            w_g_data  = bus.i_p_data;
        end else if (w_byp) begin
            w_g_valid = 1'b1;
            w_g_sec   = 1'b1;
            w_g_addr  = bus.i_s_addr;
            w_g_data  = bus.i_s_data;
        end
    end

    // Pop and push never target the same slot in one cycle (pop needs non-empty, push needs non-full).
    always_comb begin
        w_vld_nxt = r_vld;
        if (w_pop)  w_vld_nxt[r_rd_ptr] = 1'b0;
        if (w_push) w_vld_nxt[r_wr_ptr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= bus.i_s_addr;
            r_fifo_data[r_wr_ptr] <= bus.i_s_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_rd_wren <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
            r_out_sec <= 1'b0;
        end else begin
            r_vld <= w_vld_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_empty || w_pop)
                r_starve <= '0;
            else if (r_starve != STV_W'(STARVE_MAX))
                r_starve <= r_starve + 1'b1;

            // x0 writes complete the handshake but leave the visible write port untouched.
            if (w_g_valid && (w_g_addr != '0)) begin
                r_rd_wren <= 1'b1;
                r_rd_addr <= w_g_addr;
                r_rd_data <= w_g_data;
                r_out_sec <= w_g_sec;
            end else begin
                r_rd_wren <= 1'b0;
                r_out_sec <= 1'b0;
            end
        end
    end

    always_comb begin
        w_busy1 = 1'b0;
        w_busy2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_vld[i] && (r_fifo_addr[i] == bus.i_chk_addr1)) w_busy1 = 1'b1;
            if (r_vld[i] && (r_fifo_addr[i] == bus.i_chk_addr2)) w_busy2 = 1'b1;
        end
        if (r_rd_wren && r_out_sec && (r_rd_addr == bus.i_chk_addr1)) w_busy1 = 1'b1;
        if (r_rd_wren && r_out_sec && (r_rd_addr == bus.i_chk_addr2)) w_busy2 = 1'b1;
        if (bus.i_chk_addr1 == '0) w_busy1 = 1'b0;
        if (bus.i_chk_addr2 == '0) w_busy2 = 1'b0;
    end

    assign bus.o_chk_busy1 = w_busy1;
    assign bus.o_chk_busy2 = w_busy2;
    assign bus.o_rd_wren   = r_rd_wren;
    assign bus.o_rd_addr   = r_rd_addr;
    assign bus.o_rd_data   = r_rd_data;
endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Directed self-checking bench for reg_file_wb_arbiter (both WB_ARB_BYPASS_EN builds).
module tb_reg_file_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic i_clk;
    logic i_rst;
    int   n_checks;
    int   n_fail;
    logic [AW+DW-1:0] exp_q[$];

    reg_file_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_if ();

    reg_file_wb_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(2), .STARVE_MAX(4)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (u_if.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.i_p_valid   = 1'b0;
        u_if.i_p_addr    = '0;
        u_if.i_p_data    = '0;
        u_if.i_s_valid   = 1'b0;
        u_if.i_s_addr    = '0;
        u_if.i_s_data    = '0;
        u_if.i_chk_addr1 = '0;
        u_if.i_chk_addr2 = '0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        i_rst = 1'b0;
        cyc();
        n_checks++;
        if (u_if.o_rd_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren act=%0b exp=0", u_if.o_rd_wren); end
        n_checks++;
        if (u_if.o_rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr act=%0d exp=0", u_if.o_rd_addr); end
        n_checks++;
        if (u_if.o_rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_data act=%h exp=0", u_if.o_rd_data); end
        n_checks++;
        if (u_if.o_s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready act=%0b exp=1", u_if.o_s_ready); end
        for (int i = 0; i < 32; i++) begin
            u_if.i_chk_addr1 = AW'(i);
            u_if.i_chk_addr2 = AW'(31 - i);
            #1;
            n_checks++;
            if (u_if.o_chk_busy1 !== 1'b0 || u_if.o_chk_busy2 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy x%0d act=%0b%0b exp=00", i, u_if.o_chk_busy1, u_if.o_chk_busy2);
            end
        end
        idle_inputs();
    endtask

    task automatic test_primary();
        u_if.i_p_valid = 1'b1;
        u_if.i_p_addr  = 5'd5;
        u_if.i_p_data  = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (u_if.o_p_ready !== 1'b1) begin n_fail++; $display("FAIL prim_ready act=%0b exp=1", u_if.o_p_ready); end
        cyc();
        u_if.i_p_valid = 1'b0;
        n_checks++;
        if ({u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL prim_write act=%0b/%0d/%h exp=1/5/deadbeef", u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data);
        end
        cyc();
        n_checks++;
        if (u_if.o_rd_wren !== 1'b0) begin n_fail++; $display("FAIL prim_one_cycle act=%0b exp=0", u_if.o_rd_wren); end
        u_if.i_p_valid = 1'b1;
        u_if.i_p_addr  = 5'd0;
        u_if.i_p_data  = 32'h55;
        #1;
        n_checks++;
        if (u_if.o_p_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready act=%0b exp=1", u_if.o_p_ready); end
        cyc();
        u_if.i_p_valid = 1'b0;
        n_checks++;
        if ({u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL x0_write act=%0b/%0d/%h exp=0/5/deadbeef", u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_secondary();
        u_if.i_s_valid   = 1'b1;
        u_if.i_s_addr    = 5'd7;
        u_if.i_s_data    = 32'h1234;
        u_if.i_chk_addr1 = 5'd7;
        #1;
        n_checks++;
        if (u_if.o_s_ready !== 1'b1) begin n_fail++; $display("FAIL sec_ready act=%0b exp=1", u_if.o_s_ready); end
        n_checks++;
        if (u_if.o_chk_busy1 !== 1'b0) begin n_fail++; $display("FAIL sec_busy_pre act=%0b exp=0", u_if.o_chk_busy1); end
        cyc();
        u_if.i_s_valid = 1'b0;
`ifndef WB_ARB_BYPASS_EN
        n_checks++;
        if ({u_if.o_rd_wren, u_if.o_chk_busy1} !== 2'b01) begin
            n_fail++;
            $display("FAIL sec_queued act=wren%0b busy%0b exp=wren0 busy1", u_if.o_rd_wren, u_if.o_chk_busy1);
        end
        cyc();
`endif
        n_checks++;
        if ({u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data, u_if.o_chk_busy1} !== {1'b1, 5'd7, 32'h1234, 1'b1}) begin
            n_fail++;
            $display("FAIL sec_write act=%0b/%0d/%h busy%0b exp=1/7/1234 busy1",
                     u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data, u_if.o_chk_busy1);
        end
        cyc();
        n_checks++;
        if ({u_if.o_rd_wren, u_if.o_chk_busy1} !== 2'b00) begin
            n_fail++;
            $display("FAIL sec_after act=wren%0b busy%0b exp=wren0 busy0", u_if.o_rd_wren, u_if.o_chk_busy1);
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic exp_rdy;
        int   idx;
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            exp_rdy        = (c != 5);
            u_if.i_p_valid = 1'b1;
            u_if.i_p_addr  = AW'(8 + idx);
            u_if.i_p_data  = 32'h100 + 32'(idx);
            u_if.i_s_valid = (c == 0);
            u_if.i_s_addr  = 5'd3;
            u_if.i_s_data  = 32'h333;
            #1;
            n_checks++;
            if (u_if.o_p_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL starve_ready c%0d act=%0b exp=%0b", c, u_if.o_p_ready, exp_rdy);
            end
            cyc();
            n_checks++;
            if (exp_rdy) begin
                if ({u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data} !== {1'b1, AW'(8 + idx), 32'h100 + 32'(idx)}) begin
                    n_fail++;
                    $display("FAIL starve_pwrite c%0d act=%0b/%0d/%h exp=1/%0d/%h", c,
                             u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data, 8 + idx, 32'h100 + 32'(idx));
                end
                idx++;
            end else begin
                if ({u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data} !== {1'b1, 5'd3, 32'h333}) begin
                    n_fail++;
                    $display("FAIL starve_swrite c%0d act=%0b/%0d/%h exp=1/3/333", c,
                             u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data);
                end
            end
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_fill_order();
        logic [6:0] exp_s_rdy;
        logic [6:0] exp_p_rdy;
        logic [AW+DW-1:0] exp_e;
        int sidx;
        logic acc;
        exp_s_rdy = 7'b1000011;
        exp_p_rdy = 7'b1011111;
        sidx = 0;
        for (int i = 1; i <= 3; i++) exp_q.push_back({AW'(i), 32'(i) * 32'h11});
        for (int c = 0; c < 11; c++) begin
            u_if.i_p_valid = (c <= 6);
            u_if.i_p_addr  = 5'd20;
            u_if.i_p_data  = 32'hAAAA;
            u_if.i_s_valid = (sidx < 3);
            u_if.i_s_addr  = AW'(sidx + 1);
            u_if.i_s_data  = 32'(sidx + 1) * 32'h11;
            #1;
            acc = u_if.i_s_valid && u_if.o_s_ready;
            if (c <= 6) begin
                n_checks++;
                if (u_if.o_s_ready !== exp_s_rdy[c]) begin
                    n_fail++;
                    $display("FAIL fill_s_ready c%0d act=%0b exp=%0b", c, u_if.o_s_ready, exp_s_rdy[c]);
                end
                n_checks++;
                if (u_if.o_p_ready !== exp_p_rdy[c]) begin
                    n_fail++;
                    $display("FAIL fill_p_ready c%0d act=%0b exp=%0b", c, u_if.o_p_ready, exp_p_rdy[c]);
                end
            end
            cyc();
            if (acc) sidx++;
            if (u_if.o_rd_wren && u_if.o_rd_addr < 5'd20) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL fill_extra act=%0d/%h exp=none", u_if.o_rd_addr, u_if.o_rd_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({u_if.o_rd_addr, u_if.o_rd_data} !== exp_e) begin
                        n_fail++;
                        $display("FAIL fill_order act=%0d/%h exp=%0d/%h", u_if.o_rd_addr, u_if.o_rd_data,
                                 exp_e[AW+DW-1:DW], exp_e[DW-1:0]);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL fill_drain act=%0d left exp=0", exp_q.size());
            exp_q.delete();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            u_if.i_p_valid = 1'b1;
            u_if.i_p_addr  = 5'd20;
            u_if.i_p_data  = 32'hBBBB;
            u_if.i_s_valid = 1'b1;
            u_if.i_s_addr  = (c == 0) ? 5'd4 : 5'd6;
            u_if.i_s_data  = 32'h44;
            cyc();
        end
        idle_inputs();
        u_if.i_chk_addr1 = 5'd4;
        u_if.i_chk_addr2 = 5'd6;
        #1;
        n_checks++;
        if ({u_if.o_chk_busy1, u_if.o_chk_busy2, u_if.o_s_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL rmid_queued act=busy%0b%0b rdy%0b exp=busy11 rdy0", u_if.o_chk_busy1, u_if.o_chk_busy2, u_if.o_s_ready);
        end
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        n_checks++;
        if ({u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL rmid_out act=%0b/%0d/%h exp=0/0/0", u_if.o_rd_wren, u_if.o_rd_addr, u_if.o_rd_data);
        end
        n_checks++;
        if ({u_if.o_chk_busy1, u_if.o_chk_busy2, u_if.o_s_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL rmid_flags act=busy%0b%0b rdy%0b exp=busy00 rdy1", u_if.o_chk_busy1, u_if.o_chk_busy2, u_if.o_s_ready);
        end
        for (int c = 0; c < 4; c++) begin
            cyc();
            n_checks++;
            if (u_if.o_rd_wren !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_discard c%0d act=%0b/%0d exp=0", c, u_if.o_rd_wren, u_if.o_rd_addr);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_primary();
        test_secondary();
        test_starvation();
        test_fill_order();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file_wb_arbiter.md
Name: reg_file_wb_arbiter

Overview:
- Arbitrates the single write port of the 32x32 register file (x0 hard-wired zero) between two requesters.
  - Primary: pipeline writeback.
  - Secondary: load/peripheral return path, e.g. keypad MMIO loads.
- The secondary path is buffered in a small FIFO. Primary has priority, bounded by a starvation limit.
- Exposes per-register pending (scoreboard) flags so the pipeline can stall on registers with queued writes.
- Sits between the writeback stage / LSU and the register file's rd_wren/rd_addr/rd_data inputs.

Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width
- FIFO_DEPTH, 2, secondary queue entries; power of two, >=2
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may be denied before the secondary is forced a grant; >=1

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_p_valid  in  1  primary write request
- i_p_addr  in  ADDR_WIDTH  primary destination register
- i_p_data  in  DATA_WIDTH  primary write data
- o_p_ready  out  1  primary accepted this cycle (combinational)
- i_s_valid  in  1  secondary write request
- i_s_addr  in  ADDR_WIDTH  secondary destination register
- i_s_data  in  DATA_WIDTH  secondary write data
- o_s_ready  out  1  FIFO can accept; equals !full, registered-state-only
- o_rd_wren  out  1  write enable to register file
- o_rd_addr  out  ADDR_WIDTH  write address to register file
- o_rd_data  out  DATA_WIDTH  write data to register file
- i_chk_addr1  in  ADDR_WIDTH  scoreboard query 1 (rs1)
- i_chk_addr2  in  ADDR_WIDTH  scoreboard query 2 (rs2)
- o_chk_busy1  out  1  i_chk_addr1 has a pending secondary write
- o_chk_busy2  out  1  i_chk_addr2 has a pending secondary write

Behaviour:
- Reset: FIFO empty, starve counter 0, output stage cleared. o_rd_wren=0, o_rd_addr=0, o_rd_data=0, busy flags 0, o_s_ready=1 from the cycle after reset. Reset mid-operation discards all queued entries and any not-yet-written output.
- Handshakes: a transfer occurs on valid&&ready. Requesters hold addr/data stable while valid and not ready.
- FIFO push: i_s_valid&&o_s_ready. Pop occurs only on a secondary grant. Push and pop in the same cycle are legal. A full FIFO does not accept in the cycle it pops (o_s_ready is !full, no same-cycle bypass).
- Arbitration, each cycle:
  - force = FIFO non-empty && starve_cnt==STARVE_MAX.
  - If force: secondary (FIFO head) granted, o_p_ready=0.
  - Else if i_p_valid: primary granted, o_p_ready=1.
  - Else if FIFO non-empty: secondary granted.
  - Else: no grant.
  - o_p_ready=1 whenever !force, including when idle.
- Starve counter:
  - Increments, saturating at STARVE_MAX, each cycle the FIFO is non-empty and not popped.
  - Cleared on pop or when the FIFO is empty.
- Output stage (registered, latency 1):
  - The granted entry appears on o_rd_* on the next cycle.
  - o_rd_wren=1 for one cycle per grant unless addr==0.
  - Writes to x0 are consumed (handshake completes, FIFO pops) but produce o_rd_wren=0; o_rd_addr/o_rd_data hold their last values.
  - No grant: o_rd_wren=0.
- Latency:
  - Primary accepted in cycle N -> write at N+1.
  - Secondary pushed in cycle N -> earliest grant N+1 -> write at N+2.
- Scoreboard:
  - busy = query addr !=0 && (matches any valid FIFO entry || matches output stage with o_rd_wren=1 from a secondary grant).
  - Combinational from registered state.
  - Addr 0 is never busy.
- Ordering:
  - Secondary entries retire in FIFO order.
  - Primary vs secondary to the same register retire in grant order; the later grant wins.
  - The pipeline uses the busy flags to avoid such races; the arbiter does not reorder or merge.

Optional Feature:
- WB_ARB_BYPASS_EN defined: when the FIFO is empty, force=0 and i_p_valid=0, a valid secondary request is granted directly in the same cycle without being stored. The write occurs at N+1, and the busy flag is set for the output stage only.
- Undefined: all secondary traffic passes through the FIFO, with minimum latency 2.

Test Plan:
- Reset then idle -> o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_s_ready=1, busy1/busy2=0 for x0..x31.
- Primary only: x5<=0xDEADBEEF in cycle 10 -> o_rd_wren=1, addr=5, data=0xDEADBEEF in cycle 11 only. Write to x0 -> o_p_ready=1, o_rd_wren=0.
- Secondary x7<=0x1234 with primary idle -> o_rd_* shows x7/0x1234 two cycles later (one cycle with WB_ARB_BYPASS_EN). o_chk_busy1 with i_chk_addr1=7 is high until the write cycle, inclusive, then low.
- Primary valid every cycle, secondary pushes x3 -> after STARVE_MAX=4 denied cycles, o_p_ready=0 for one cycle and x3 is written. Primary resumes the next cycle.
- Fill FIFO with x1, x2 while primary is busy -> o_s_ready=0. Third request is held and accepted only the cycle after a pop. Retire order is x1, x2, x3.
- Assert i_rst with two FIFO entries queued -> next cycle o_rd_wren=0, busy flags 0, o_s_ready=1. Queued entries are never written.
